sm_als_responder: RTL

//  SPI responder that models the ambient light sensor (ADC081S021-style) at the far end of alsCS/alsSCK/alsSDO.

---
 rtl/sm_als_responder.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sm_als_responder.sv
// -----------------------------------------------------------------------------
// sm_als_responder
//
// SPI responder that stands in for the ambient light sensor (ADC081S021-style)
// hanging off alsCS/alsSCK/alsSDO. It answers the on-chip SPI master so the
// sensor path can be exercised in simulation and in FPGA loopback.
//
// One frame of FRAME_BITS bits is served per CS-low window, MSB first:
//     {LEAD_ZEROS zeros, value[DATA_WIDTH-1:0], trailing zeros}
// The number of trailing zeros is FRAME_BITS - LEAD_ZEROS - DATA_WIDTH and
// must not be negative.
//
// alsCS and alsSCK are treated as plain asynchronous data inputs. They are
// oversampled by clk (two synchroniser flops plus one history flop each) and
// are never used as clocks.
//
// Ports
//   clk        in   1           system clock (only clock in the module)
//   rst        in   1           synchronous reset, active-high
//   alsCS      in   1           chip select from master, active-low, async
//   alsSCK     in   1           SPI clock from master, async
//   alsSDO     out  1           serial data to master, registered; updates
//                               3 clk edges after an SCK falling edge
//   value      in   DATA_WIDTH  sensor value, captured when CS falls
//   busy       out  1           frame in progress (SHIFT or DONE)
//   frameDone  out  1           1-clk pulse, CS released after a full frame
//   frameAbort out  1           1-clk pulse, CS released before frame end
//   frameCnt   out  CNT_WIDTH   completed-frame counter, wraps
// -----------------------------------------------------------------------------
module sm_als_responder #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEAD_ZEROS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alsCS,
    input  logic                  alsSCK,
    output logic                  alsSDO,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  frameAbort,
    output logic [CNT_WIDTH-1:0]  frameCnt
);

    localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
    localparam int BIT_CNT_W   = $clog2(FRAME_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS);

    // Index of each pin inside the synchroniser vectors.
    localparam int PIN_CS  = 0;
    localparam int PIN_SCK = 1;
    localparam int NUM_PINS = 2;

    // -------------------------------------------------------------------------
    // Input synchronisers: meta -> sync (2-flop synchroniser), then history.
    // All stages reset to 1 so that no false falling edge appears right after
    // reset.
    // -------------------------------------------------------------------------
    logic [NUM_PINS-1:0] pin_in;
    logic [NUM_PINS-1:0] sync_vec;
    logic [NUM_PINS-1:0] hist_vec;

    assign pin_in[PIN_CS]  = alsCS;
    assign pin_in[PIN_SCK] = alsSCK;

    generate
        for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic hist_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    hist_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_in[gi];
                    sync_reg <= meta_reg;
                    hist_reg <= sync_reg;
                end
            end

            assign sync_vec[gi] = sync_reg;
            assign hist_vec[gi] = hist_reg;
        end
    endgenerate

    logic cs_s;
    logic cs_p;
    logic sck_s;
    logic sck_p;
    logic cs_fall;
    logic cs_rise;
    logic sck_fall;

    assign cs_s     = sync_vec[PIN_CS];
    assign cs_p     = hist_vec[PIN_CS];
    assign sck_s    = sync_vec[PIN_SCK];
    assign sck_p    = hist_vec[PIN_SCK];
    assign cs_fall  = cs_p & ~cs_s;
    assign cs_rise  = ~cs_p & cs_s;
    assign sck_fall = sck_p & ~sck_s;

    // -------------------------------------------------------------------------
    // Synchroniser fill tracking. Right after reset the sync flops hold their
    // forced 1, not the pin. WAIT_HIGH must only trust cs_s once it carries a
    // real pin sample (two clk edges), otherwise a CS held low through reset
    // would look high for a moment and then produce a false CS fall.
    // -------------------------------------------------------------------------
    logic [1:0] fill_reg;
    logic       sync_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_reg <= 2'd0;
        end else if (fill_reg != 2'd2) begin
            fill_reg <= fill_reg + 2'd1;
        end
    end

    assign sync_valid = (fill_reg == 2'd2);

    // Frame image loaded into the shift register at CS fall.
    logic [FRAME_BITS-1:0] frame_word;
    assign frame_word = FRAME_BITS'(value) << TRAIL_ZEROS;

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                 state_reg,   state_next;
    logic                   sdo_reg,     sdo_next;
    logic                   busy_reg,    busy_next;
    logic                   done_reg,    done_next;
    logic                   abort_reg,   abort_next;
    logic [CNT_WIDTH-1:0]   cnt_reg,     cnt_next;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [FRAME_BITS-1:0]  shreg_reg,   shreg_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= WAIT_HIGH;
            sdo_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            abort_reg   <= 1'b0;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            sdo_reg     <= sdo_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            abort_reg   <= abort_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sdo_next     = sdo_reg;
        done_next    = 1'b0;
        abort_next   = 1'b0;
        cnt_next     = cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;

        case (state_reg)
            WAIT_HIGH: begin
                sdo_next = 1'b0;
                if (sync_valid && cs_s) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                sdo_next = 1'b0;
                // SCK activity here is ignored, including an SCK fall that
                // coincides with the CS fall.
                if (cs_fall) begin
                    shreg_next   = frame_word;
                    sdo_next     = frame_word[FRAME_BITS-1];
                    bit_cnt_next = BIT_CNT_W'(1);
                    state_next   = SHIFT;
                end
            end

            SHIFT: begin
                // CS release wins over a simultaneous SCK fall.
                if (cs_rise) begin
                    abort_next = 1'b1;
                    sdo_next   = 1'b0;
                    state_next = IDLE;
                end else if (sck_fall) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        sdo_next   = 1'b0;
                        state_next = DONE;
                    end else begin
                        // Bit now at MSB after the shift is the next to send.
                        shreg_next   = shreg_reg << 1;
                        sdo_next     = shreg_reg[FRAME_BITS-2];
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end

            DONE: begin
                // Extra SCK cycles past the frame read back zeros.
                sdo_next = 1'b0;
                if (cs_rise) begin
                    done_next  = 1'b1;
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                sdo_next   = 1'b0;
                state_next = WAIT_HIGH;
            end
        endcase

        busy_next = (state_next == SHIFT) || (state_next == DONE);
    end

    assign alsSDO     = sdo_reg;
    assign busy       = busy_reg;
    assign frameDone  = done_reg;
    assign frameAbort = abort_reg;
    assign frameCnt   = cnt_reg;

endmodule
